// File: rtl/fifo_rd_packer.sv
// Read-side packer for the async FIFO: pops bytes, packs NBYTES lanes per word and
// emits full words, or partial words on an explicit flush or after an idle timeout.
module fifo_rd_packer #(
    parameter int DWIDTH  = 8,
    parameter int NBYTES  = 4,
    parameter int BCW     = 3,
    parameter int TIMEOUT = 0
) (
    input  logic                     rclk,
    input  logic                     reset_L,
    input  logic                     empty,
    output logic                     pop,
    input  logic [DWIDTH-1:0]        rdata,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DWIDTH*NBYTES-1:0] out_data,
    output logic [BCW-1:0]           out_bcnt,
    output logic                     busy
);
    localparam int             IW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [BCW-1:0] FULL      = BCW'(NBYTES);
    localparam logic [BCW-1:0] LAST      = BCW'(NBYTES - 1);
    localparam logic [IW-1:0]  IDLE_LAST = IW'(TIMEOUT - 1);

    logic [BCW-1:0]                cnt_q, cnt_d;
    logic                          inflight_q;
    logic                          flush_pend_q, flush_pend_d;
    logic [IW-1:0]                 idle_q, idle_d;
    logic [NBYTES-1:0][DWIDTH-1:0] pack_q, pack_d;
    logic                          out_valid_q, out_valid_d;
    logic [NBYTES-1:0][DWIDTH-1:0] out_data_q, out_data_d;
    logic [BCW-1:0]                out_bcnt_q, out_bcnt_d;

    logic           out_free, complete, pack_load, pop_c, idle_inc, to_hit, flush_req;
    logic [BCW-1:0] occ;

    always_comb begin
        out_free  = !out_valid_q || out_ready;
        occ       = cnt_q + BCW'(inflight_q);
        complete  = inflight_q && (cnt_q == LAST);
        // The second term lets the last byte of a word and the first byte of the
        // next one overlap, so a steady stream pops every cycle.
        pop_c     = !empty && !flush_pend_q &&
                    ((occ < FULL) || ((occ == FULL) && inflight_q && out_free));
        pack_load = !inflight_q && out_free && (cnt_q != '0) &&
                    ((cnt_q == FULL) || flush_pend_q);
        idle_inc  = (cnt_q != '0) && !pop_c && !inflight_q && !flush_pend_q;
        to_hit    = (TIMEOUT > 0) && idle_inc && (idle_q == IDLE_LAST);
        flush_req = flush && ((cnt_q != '0) || inflight_q) && !complete;

        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q;
        pack_d       = pack_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_bcnt_d   = out_bcnt_q;
        idle_d       = (idle_inc && !to_hit) ? idle_q + IW'(1) : '0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (inflight_q) begin
            if (complete && out_free) begin
                for (int i = 0; i < NBYTES; i++) begin
                    out_data_d[i] = (i == NBYTES - 1) ? rdata : pack_q[i];
                end
                out_bcnt_d  = FULL;
                out_valid_d = 1'b1;
                cnt_d       = '0;
            end else begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (BCW'(i) == cnt_q) begin
                        pack_d[i] = rdata;
                    end
                end
                cnt_d = cnt_q + BCW'(1);
            end
        end else if (pack_load) begin
            for (int i = 0; i < NBYTES; i++) begin
                out_data_d[i] = (BCW'(i) < cnt_q) ? pack_q[i] : '0;
            end
            out_bcnt_d   = cnt_q;
            out_valid_d  = 1'b1;
            cnt_d        = '0;
            flush_pend_d = 1'b0;
        end else if (cnt_q == '0) begin
            flush_pend_d = 1'b0;
        end

        // A request arriving while the pack register is already leaving has nothing to flush.
        if ((flush_req || to_hit) && !pack_load) begin
            flush_pend_d = 1'b1;
        end
    end

    always_ff @(posedge rclk or negedge reset_L) begin
        if (!reset_L) begin
            cnt_q        <= '0;
            inflight_q   <= 1'b0;
            flush_pend_q <= 1'b0;
            idle_q       <= '0;
            pack_q       <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_bcnt_q   <= '0;
        end else begin
            cnt_q        <= cnt_d;
            inflight_q   <= pop;
            flush_pend_q <= flush_pend_d;
            idle_q       <= idle_d;
            pack_q       <= pack_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_bcnt_q   <= out_bcnt_d;
        end
    end

    // pop is combinational on empty so it never requests from an empty FIFO.
    assign pop       = pop_c & reset_L;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_bcnt  = out_bcnt_q;
    assign busy      = (cnt_q != '0) | inflight_q | out_valid_q | flush_pend_q;
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: FIFO model plus an in-order byte scoreboard; every accepted
// word must carry the next bcnt bytes in lane order with unused lanes zero.
module tb_fifo_rd_packer;
    logic        rclk = 1'b0;
    logic        reset_L, empty, pop, flush, out_valid, out_ready, busy;
    logic [7:0]  rdata;
    logic [31:0] out_data;
    logic [2:0]  out_bcnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0]  fifo[$];
    logic [7:0]  exp_bytes[$];
    logic [31:0] got_d[$];
    logic [2:0]  got_b[$];
    int          got_cyc[$];
    int          pop_log[$];

    always #5 rclk = ~rclk;

    fifo_rd_packer #(.DWIDTH(8), .NBYTES(4), .BCW(3), .TIMEOUT(8)) u_dut (
        .rclk      (rclk),
        .reset_L   (reset_L),
        .empty     (empty),
        .pop       (pop),
        .rdata     (rdata),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_bcnt  (out_bcnt),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        exp_bytes.push_back(b);
        empty = 1'b0;
    endtask

    task automatic clear_logs();
        got_d.delete();
        got_b.delete();
        got_cyc.delete();
        pop_log.delete();
    endtask

    // Called at posedge+1; samples at posedge-1, then advances one cycle.
    task automatic tick();
        logic        p, e, acc;
        logic [31:0] d;
        logic [2:0]  b;
        int          c;
        #8;
        p   = pop;
        e   = empty;
        acc = out_valid && out_ready;
        d   = out_data;
        b   = out_bcnt;
        c   = cyc;
        check("no_pop_when_empty", 32'(p & e), 32'd0);
        if (p) pop_log.push_back(c);
        @(posedge rclk);
        #1;
        cyc++;
        flush = 1'b0;
        if (p && fifo.size() > 0) rdata = fifo.pop_front();
        if (acc) begin
            got_d.push_back(d);
            got_b.push_back(b);
            got_cyc.push_back(c);
            check("bcnt_range", 32'(b >= 3'd1 && b <= 3'd4), 32'd1);
            for (int i = 0; i < 4; i++) begin
                logic [7:0] e8;
                e8 = 8'h00;
                if (i < int'(b)) begin
                    check("byte_available", 32'(exp_bytes.size() != 0), 32'd1);
                    if (exp_bytes.size() != 0) e8 = exp_bytes.pop_front();
                end
                check("lane", 32'(d[8*i +: 8]), 32'(e8));
            end
        end
        empty = (fifo.size() == 0);
    endtask

    initial begin
        reset_L = 1'b0; empty = 1'b1; flush = 1'b0; out_ready = 1'b1; rdata = 8'h00;
        @(posedge rclk);
        #1;
        check("rst_pop", 32'(pop), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_bcnt", 32'(out_bcnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        tick(); tick();
        reset_L = 1'b1;

        for (int k = 0; k < 50; k++) begin
            tick();
            check("idle_pop", 32'(pop), 32'd0);
            check("idle_valid", 32'(out_valid), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
        end

        // Streaming two full words with out_ready high
        clear_logs();
        for (int k = 1; k <= 8; k++) push(8'(k));
        repeat (14) tick();
        check("t2_pops", 32'(pop_log.size()), 32'd8);
        if (pop_log.size() >= 8) check("t2_pop_run", 32'(pop_log[7] - pop_log[0]), 32'd7);
        check("t2_words", 32'(got_d.size()), 32'd2);
        if (got_d.size() >= 2 && pop_log.size() >= 4) begin
            check("t2_w0", got_d[0], 32'h04030201);
            check("t2_b0", 32'(got_b[0]), 32'd4);
            check("t2_w1", got_d[1], 32'h08070605);
            check("t2_b1", 32'(got_b[1]), 32'd4);
            check("t2_latency", 32'(got_cyc[0] - pop_log[3]), 32'd2);
        end

        // Back-pressure: output and pack register both full
        clear_logs();
        out_ready = 1'b0;
        for (int k = 1; k <= 12; k++) push(8'(k));
        repeat (30) tick();
        check("t3_hold_valid", 32'(out_valid), 32'd1);
        check("t3_hold_data", out_data, 32'h04030201);
        check("t3_hold_bcnt", 32'(out_bcnt), 32'd4);
        check("t3_pop_stalled", 32'(pop), 32'd0);
        check("t3_fifo_left", 32'(fifo.size()), 32'd4);
        check("t3_busy", 32'(busy), 32'd1);
        out_ready = 1'b1;
        repeat (20) tick();
        check("t3_words", 32'(got_d.size()), 32'd3);
        if (got_d.size() >= 3) begin
            check("t3_w0", got_d[0], 32'h04030201);
            check("t3_w1", got_d[1], 32'h08070605);
            check("t3_w2", got_d[2], 32'h0C0B0A09);
        end

        // Explicit flush of a partial word, then a flush with nothing held
        clear_logs();
        push(8'hAA); push(8'hBB);
        repeat (4) tick();
        flush = 1'b1;
        tick();
        repeat (5) tick();
        check("t4_words", 32'(got_d.size()), 32'd1);
        if (got_d.size() >= 1) begin
            check("t4_data", got_d[0], 32'h0000BBAA);
            check("t4_bcnt", 32'(got_b[0]), 32'd2);
        end
        flush = 1'b1;
        tick();
        repeat (10) tick();
        check("t4_empty_flush_words", 32'(got_d.size()), 32'd1);
        check("t4_empty_flush_valid", 32'(out_valid), 32'd0);
        check("t4_empty_flush_busy", 32'(busy), 32'd0);

        // Idle timeout flushes a 3-byte word
        clear_logs();
        push(8'h11); push(8'h22); push(8'h33);
        repeat (20) tick();
        check("t5_words", 32'(got_d.size()), 32'd1);
        if (got_d.size() >= 1 && pop_log.size() >= 3) begin
            check("t5_data", got_d[0], 32'h00332211);
            check("t5_bcnt", 32'(got_b[0]), 32'd3);
            check("t5_latency", 32'(got_cyc[0] - pop_log[2]), 32'd11);
        end

        // Asynchronous reset while a word waits and two bytes are packed
        clear_logs();
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) push(8'(8'h31 + k));
        repeat (10) tick();
        check("t6_pre_valid", 32'(out_valid), 32'd1);
        check("t6_pre_busy", 32'(busy), 32'd1);
        push(8'h99);
        reset_L = 1'b0;
        #1;
        check("t6_rst_pop", 32'(pop), 32'd0);
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        fifo.delete();
        exp_bytes.delete();
        empty = 1'b1;
        @(posedge rclk);
        #1;
        tick();
        reset_L = 1'b1;
        clear_logs();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) push(8'(8'h55 + k));
        repeat (12) tick();
        check("t6_words", 32'(got_d.size()), 32'd1);
        if (got_d.size() >= 1) begin
            check("t6_data", got_d[0], 32'h58575655);
            check("t6_bcnt", 32'(got_b[0]), 32'd4);
        end

        // Random traffic, back-pressure and flushes against the byte scoreboard
        clear_logs();
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 99) < 45) push(8'($urandom));
            out_ready = ($urandom_range(0, 99) < 60);
            flush     = ($urandom_range(0, 99) < 4);
            tick();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 200 && (exp_bytes.size() != 0 || fifo.size() != 0 || out_valid); k++) begin
            flush = (k % 4 == 0);
            tick();
        end
        repeat (3) tick();
        check("rand_drained", 32'(exp_bytes.size()), 32'd0);
        check("rand_fifo_empty", 32'(fifo.size()), 32'd0);
        check("rand_valid_low", 32'(out_valid), 32'd0);
        check("rand_busy_low", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
